kronos_seqcmp: RTL and testbench

Sequential, parametrised magnitude comparator with signed/unsigned mode. It compares two WIDTH-bit operands one CHUNK-bit slice per cycle, most-significant slice first, and terminates early on the first differing slice. Requests and responses use valid/ready handshakes. It serves multi-cycle compare and branch resolution paths where a full-width single-cycle comparator is too costly, and it generalises the fixed 32-bit / 4x8-bit comparator chain.

---
 rtl/kronos_cmp_pkg.sv | 32 +++
 rtl/kronos_chunk_cmp.sv | 36 +++
 rtl/kronos_seqcmp.sv | 153 +++++++++++++++
 tb/tb_kronos_seqcmp.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kronos_cmp_pkg
// Description : Shared types for the sequential magnitude comparator. Holds
//               the result codes, the controller states and the code-merge
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package kronos_cmp_pkg;

  // Result code. The value 2'b11 is never produced.
  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_LT = 2'b01,
    CMP_GT = 2'b10
  } cmp_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMP  = 2'b01,
    DONE = 2'b10
  } seqcmp_state_t;

  // Merge a more-significant code with a less-significant one. The upper
  // code decides unless it reports equality.
  function automatic cmp_t cmp_merge(input cmp_t hi, input cmp_t lo);
    return (hi != CMP_EQ) ? hi : lo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kronos_chunk_cmp.sv
`default_nettype none
// ============================================================================
// Module      : kronos_chunk_cmp
// Description : Combinational compare of one W-bit slice. The result is
//               EQ, LT or GT, and the slice is treated as two's complement
//               when sgn is set.
// Revision    : 1.0 - initial release
// ============================================================================
module kronos_chunk_cmp
  import kronos_cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sgn,
  output logic [1:0]   c
);

  logic w_lt;

  // Pick the signed or unsigned less-than, then encode the slice code.
  always_comb begin
    c    = CMP_EQ;
    w_lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    if (a == b) begin
      c = CMP_EQ;
    end else if (w_lt) begin
      c = CMP_LT;
    end else begin
      c = CMP_GT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kronos_seqcmp.sv
`default_nettype none
// ============================================================================
// Module      : kronos_seqcmp
// Description : Sequential magnitude comparator. Compares two WIDTH-bit
//               operands one CHUNK-bit slice per cycle, starting at the MSB
//               slice, and stops at the first slice that differs. Requests
//               and responses use valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module kronos_seqcmp
  import kronos_cmp_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int SW     = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_signed,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [1:0]       rsp_cmp,
  output logic [SW-1:0]    rsp_steps
);

  localparam int            IW        = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] c_idx_top = IW'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $fatal(1, "kronos_seqcmp: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  seqcmp_state_t                r_state;
  seqcmp_state_t                w_state_nxt;
  logic [NCHUNK-1:0][CHUNK-1:0] r_a;
  logic [NCHUNK-1:0][CHUNK-1:0] r_b;
  logic                         r_sgn;
  logic [IW-1:0]                r_idx;
  logic [SW-1:0]                r_steps;
  logic [1:0]                   r_cmp;
  logic [SW-1:0]                r_rsp_steps;

  logic [CHUNK-1:0]             w_sa;
  logic [CHUNK-1:0]             w_sb;
  logic                         w_ssgn;
  logic [1:0]                   w_code;
  logic                         w_last;

  // Slice select. With a single slice there is nothing to index.
  generate
    if (NCHUNK == 1) begin : g_single
      assign w_sa = r_a[0];
      assign w_sb = r_b[0];
    end else begin : g_multi
      assign w_sa = r_a[r_idx];
      assign w_sb = r_b[r_idx];
    end
  endgenerate

  // Only the top slice carries the sign. Lower slices are plain magnitudes.
  assign w_ssgn = r_sgn && (r_idx == c_idx_top);

  kronos_chunk_cmp #(
    .W   (CHUNK)
  ) u_chunk_cmp (
    .a   (w_sa),
    .b   (w_sb),
    .sgn (w_ssgn),
    .c   (w_code)
  );

  // A differing slice is final. Slice 0 is the last one to examine.
  assign w_last = (w_code != CMP_EQ) || (r_idx == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_rdy     = 1'b0;
    rsp_vld     = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) begin
          w_state_nxt = CMP;
        end
      end
      CMP: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        rsp_vld = 1'b1;
        if (rsp_rdy) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, slice walk and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sgn       <= 1'b0;
      r_idx       <= '0;
      r_steps     <= '0;
      r_cmp       <= CMP_EQ;
      r_rsp_steps <= '0;
    end else begin
      if ((r_state == IDLE) && req_vld) begin
        r_a     <= req_a;
        r_b     <= req_b;
        r_sgn   <= req_signed;
        r_idx   <= c_idx_top;
        r_steps <= '0;
      end else if (r_state == CMP) begin
        r_steps <= r_steps + SW'(1);
        if (w_last) begin
          r_cmp       <= w_code;
          r_rsp_steps <= r_steps + SW'(1);
        end else begin
          r_idx <= r_idx - IW'(1);
        end
      end
    end
  end

  assign rsp_cmp   = r_cmp;
  assign rsp_steps = r_rsp_steps;

endmodule
`default_nettype wire

// File: tb/tb_kronos_seqcmp.sv
`default_nettype none
// ============================================================================
// Module      : tb_kronos_seqcmp
// Description : Self-checking bench for kronos_seqcmp. Instances are built
//               at 32/8, 32/32 and 16/4. A vector table is followed by the
//               backpressure and reset sequences and a randomized sweep,
//               all checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kronos_seqcmp;
  import kronos_cmp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_vld    [3];
  logic        req_signed [3];
  logic        rsp_rdy    [3];
  logic [31:0] req_a      [3];
  logic [31:0] req_b      [3];

  logic       rrdy0, rrdy1, rrdy2;
  logic       rvld0, rvld1, rvld2;
  logic [1:0] cmp0, cmp1, cmp2;
  logic [2:0] st0;
  logic [0:0] st1;
  logic [2:0] st2;

  kronos_seqcmp #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst(rst), .req_vld(req_vld[0]), .req_rdy(rrdy0),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_signed(req_signed[0]),
    .rsp_vld(rvld0), .rsp_rdy(rsp_rdy[0]), .rsp_cmp(cmp0), .rsp_steps(st0)
  );
  kronos_seqcmp #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk(clk), .rst(rst), .req_vld(req_vld[1]), .req_rdy(rrdy1),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_signed(req_signed[1]),
    .rsp_vld(rvld1), .rsp_rdy(rsp_rdy[1]), .rsp_cmp(cmp1), .rsp_steps(st1)
  );
  kronos_seqcmp #(.WIDTH(16), .CHUNK(4)) u_dut2 (
    .clk(clk), .rst(rst), .req_vld(req_vld[2]), .req_rdy(rrdy2),
    .req_a(req_a[2][15:0]), .req_b(req_b[2][15:0]), .req_signed(req_signed[2]),
    .rsp_vld(rvld2), .rsp_rdy(rsp_rdy[2]), .rsp_cmp(cmp2), .rsp_steps(st2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  function automatic int f_width(input int i);
    return (i == 2) ? 16 : 32;
  endfunction

  function automatic int f_chunk(input int i);
    case (i)
      0:       return 8;
      1:       return 32;
      default: return 4;
    endcase
  endfunction

  function automatic int get_rrdy(input int i);
    case (i)
      0:       return int'(rrdy0);
      1:       return int'(rrdy1);
      default: return int'(rrdy2);
    endcase
  endfunction

  function automatic int get_rvld(input int i);
    case (i)
      0:       return int'(rvld0);
      1:       return int'(rvld1);
      default: return int'(rvld2);
    endcase
  endfunction

  function automatic int get_cmp(input int i);
    case (i)
      0:       return int'(cmp0);
      1:       return int'(cmp1);
      default: return int'(cmp2);
    endcase
  endfunction

  function automatic int get_steps(input int i);
    case (i)
      0:       return int'(st0);
      1:       return int'(st1);
      default: return int'(st2);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model. Left-align both operands so that bit 31 is the sign
  // bit and compare them with plain arithmetic. The step count is the slice
  // that holds the most-significant differing bit.
  task automatic model(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic s, output int c, output int st);
    int          w;
    int          ch;
    int          q;
    logic [31:0] al;
    logic [31:0] bl;
    logic [31:0] x;
    w  = f_width(i);
    ch = f_chunk(i);
    al = a << (32 - w);
    bl = b << (32 - w);
    if (al == bl) c = 0;
    else if (s ? ($signed(al) < $signed(bl)) : (al < bl)) c = 1;
    else c = 2;
    x  = al ^ bl;
    st = w / ch;
    q  = 0;
    while ((q < w) && !x[31 - q]) q++;
    if (q < w) st = q / ch + 1;
  endtask

  // One full transaction. Latency, result and every stall cycle are checked
  // against the expected code and step count.
  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int stall, input bit corrupt,
                        input int exp_c, input int exp_st, input string tag);
    int lat;
    chk($sformatf("%s/i%0d req_rdy_idle", tag, i), get_rrdy(i), 1);
    req_a[i]      = a;
    req_b[i]      = b;
    req_signed[i] = s;
    req_vld[i]    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_vld[i] = 1'b0;
    if (corrupt) begin
      req_a[i] = ~a;
      req_b[i] = a;
    end
    lat = 1;
    while ((get_rvld(i) == 0) && (lat < 40)) begin
      chk($sformatf("%s/i%0d req_rdy_cmp", tag, i), get_rrdy(i), 0);
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) begin
      chk($sformatf("%s/i%0d rsp_timeout", tag, i), 0, 1);
      return;
    end
    chk($sformatf("%s/i%0d latency", tag, i), lat, exp_st + 1);
    chk($sformatf("%s/i%0d cmp", tag, i), get_cmp(i), exp_c);
    chk($sformatf("%s/i%0d steps", tag, i), get_steps(i), exp_st);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk($sformatf("%s/i%0d stall_vld", tag, i), get_rvld(i), 1);
      chk($sformatf("%s/i%0d stall_rdy", tag, i), get_rrdy(i), 0);
      chk($sformatf("%s/i%0d stall_cmp", tag, i), get_cmp(i), exp_c);
      chk($sformatf("%s/i%0d stall_steps", tag, i), get_steps(i), exp_st);
    end
    rsp_rdy[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_rdy[i] = 1'b0;
    chk($sformatf("%s/i%0d post_vld", tag, i), get_rvld(i), 0);
    chk($sformatf("%s/i%0d post_rdy", tag, i), get_rrdy(i), 1);
  endtask

  typedef struct {
    int          inst;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int          c;
    int          st;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ec;
    int          est;
    int          seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] msk;
    logic        rs;
    int          w;

    vecs[0]  = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 1};
    vecs[1]  = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2, 1};
    vecs[2]  = '{0, 32'h1234_5678, 32'h1234_5678, 1'b1, 0, 4};
    vecs[3]  = '{0, 32'h1234_5600, 32'h1234_5601, 1'b0, 1, 4};
    vecs[4]  = '{0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1, 1};
    vecs[5]  = '{0, 32'h12FF_0000, 32'h1200_0000, 1'b1, 2, 2};
    vecs[6]  = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 1};
    vecs[7]  = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2, 1};
    vecs[8]  = '{1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 0, 1};
    vecs[9]  = '{2, 32'h0000_8000, 32'h0000_7FFF, 1'b1, 1, 1};
    vecs[10] = '{2, 32'h0000_1234, 32'h0000_1235, 1'b0, 1, 4};
    vecs[11] = '{2, 32'h0000_1234, 32'h0000_1204, 1'b1, 2, 3};

    for (int i = 0; i < 3; i++) begin
      req_vld[i]    = 1'b0;
      req_signed[i] = 1'b0;
      rsp_rdy[i]    = 1'b0;
      req_a[i]      = '0;
      req_b[i]      = '0;
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset/i%0d req_rdy", i), get_rrdy(i), 1);
      chk($sformatf("reset/i%0d rsp_vld", i), get_rvld(i), 0);
      chk($sformatf("reset/i%0d rsp_cmp", i), get_cmp(i), 0);
      chk($sformatf("reset/i%0d rsp_steps", i), get_steps(i), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      run_op(vecs[v].inst, vecs[v].a, vecs[v].b, vecs[v].s, 0, 1'b0,
             vecs[v].c, vecs[v].st, $sformatf("vec%0d", v));
    end

    // Three stall cycles in DONE, operands rewritten while CMP is running.
    run_op(0, 32'h0000_0001, 32'h0000_0002, 1'b0, 3, 1'b1, 1, 4, "bp");

    // Reset while CMP is running, after two slices have been examined.
    req_a[0] = 32'h5555_AAAA;
    req_b[0] = 32'h5555_AAAA;
    req_signed[0] = 1'b0;
    req_vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_vld[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rstmid pre_vld", get_rvld(0), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid req_rdy", get_rrdy(0), 1);
    chk("rstmid rsp_vld", get_rvld(0), 0);
    chk("rstmid rsp_steps", get_steps(0), 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (get_rvld(0) != 0) seen++;
    end
    chk("rstmid no_response", seen, 0);
    run_op(0, 32'h0000_0010, 32'h0000_0100, 1'b1, 0, 1'b0, 1, 3, "rstmid_after");

    // Randomized sweep on every instance.
    for (int i = 0; i < 3; i++) begin
      w   = f_width(i);
      msk = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      for (int n = 0; n < 1024; n++) begin
        ra = $urandom & msk;
        case ($urandom_range(0, 9))
          0:       rb = ra;
          1, 2, 3: rb = ra ^ (32'h1 << $urandom_range(0, w - 1));
          default: rb = $urandom & msk;
        endcase
        rs = 1'($urandom_range(0, 1));
        model(i, ra, rb, rs, ec, est);
        run_op(i, ra, rb, rs, ($urandom_range(0, 9) < 3) ? $urandom_range(1, 2) : 0,
               1'b0, ec, est, $sformatf("rnd%0d", n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
